// File: rtl/brick_mem_sched_pkg.sv
// brick_pkg: shared constants and types for the level brick memory users
// (scheduler, collision, scoring). Brick types, level size, bus widths and
// the scheduler state encoding.
package brick_pkg;

    localparam int NUM_BRICKS = 80;
    localparam int ADDR_W     = 8;
    localparam int TYPE_W     = 3;
    localparam int CNT_W      = 7;
    localparam int SCORE_W    = 8;

    localparam logic [TYPE_W-1:0] NOBRICK = 3'd0;
    localparam logic [TYPE_W-1:0] RED     = 3'd1;
    localparam logic [TYPE_W-1:0] BROWN   = 3'd2;
    localparam logic [TYPE_W-1:0] SRED    = 3'd3;
    localparam logic [TYPE_W-1:0] SBROWN  = 3'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        HIT_WR = 2'd2
    } sched_state_e;

endpackage

// File: rtl/brick_mem_sched_if.sv
// brick_mem_sched_if: request/grant bundle between the memory clients
// (levelDraw, brickCollision, game FSM) and brick_mem_sched.
//   master: requesters drive *_req / *_addr, receive grants and read data
//   slave : scheduler drives grants, valids, rd_type, hit_done, hit_points
interface brick_mem_sched_if;
    import brick_pkg::*;

    logic              draw_req;
    logic              col_req;
    logic              hit_req;
    logic [ADDR_W-1:0] draw_addr;
    logic [ADDR_W-1:0] col_addr;
    logic [ADDR_W-1:0] hit_addr;
    logic              draw_gnt;
    logic              col_gnt;
    logic              hit_gnt;
    logic              draw_valid;
    logic              col_valid;
    logic [TYPE_W-1:0] rd_type;
    logic              hit_done;
    logic [TYPE_W-1:0] hit_points;

    modport master (
        output draw_req, col_req, hit_req, draw_addr, col_addr, hit_addr,
        input  draw_gnt, col_gnt, hit_gnt, draw_valid, col_valid, rd_type,
               hit_done, hit_points
    );

    modport slave (
        input  draw_req, col_req, hit_req, draw_addr, col_addr, hit_addr,
        output draw_gnt, col_gnt, hit_gnt, draw_valid, col_valid, rd_type,
               hit_done, hit_points
    );

endinterface

// File: rtl/brick_mem_sched_tally.sv
// brick_tally: level bookkeeping for brick_mem_sched.
//   clear      : scan entry, zero the brick count
//   scan_inc   : a scanned brick was non-empty
//   hit_upd    : a hit completed with old type hit_old
//   scan_done  : first full scan finished (sticky until reset)
//   scan_busy  : scan in progress, masks level_clear
//   bricks_left, score (saturating), level_clear
module brick_tally
    import brick_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               scan_inc,
    input  logic               hit_upd,
    input  logic [TYPE_W-1:0]  hit_old,
    input  logic               scan_done,
    input  logic               scan_busy,
    output logic [CNT_W-1:0]   bricks_left,
    output logic [SCORE_W-1:0] score,
    output logic               level_clear
);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               scanned_q, scanned_d;
    logic [SCORE_W:0]   score_sum;

    always_comb begin
        cnt_d     = cnt_q;
        score_d   = score_q;
        scanned_d = scanned_q | scan_done;
        score_sum = {1'b0, score_q} + {{(SCORE_W+1-TYPE_W){1'b0}}, hit_old};
        if (clear) begin
            cnt_d = '0;
        end else if (scan_inc) begin
            cnt_d = cnt_q + 1'b1;
        end else if (hit_upd && hit_old == RED && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (hit_upd) begin
            score_d = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            score_q   <= '0;
            scanned_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            score_q   <= score_d;
            scanned_q <= scanned_d;
        end
    end

    assign bricks_left = cnt_q;
    assign score       = score_q;
    assign level_clear = scanned_q && (cnt_q == '0) && !scan_busy;

endmodule

// File: rtl/brick_mem_sched.sv
// brick_mem_sched: single-port level memory scheduler.
// Fixed-priority arbitration (hit > col > draw) of reads and hit
// read-modify-write updates, plus a full-level scan that counts bricks.
//   clk, reset (async active-low), level_start (scan pulse), scan_busy
//   bus           : request/grant interface (slave side)
//   mem_addr/wren/data, mem_q (1-cycle read latency)
//   bricks_left, score, level_clear
//
// state  | meaning
// IDLE   | arbitrate one request per cycle, reads pipeline back to back
// SCAN   | read addresses 0..NUM_BRICKS-1, then one tail cycle to count last data
// HIT_WR | old type on mem_q, write old-1 back, report points
module brick_mem_sched
    import brick_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               level_start,
    output logic               scan_busy,
    brick_mem_sched_if.slave   bus,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_wren,
    output logic [TYPE_W-1:0]  mem_data,
    input  logic [TYPE_W-1:0]  mem_q,
    output logic [CNT_W-1:0]   bricks_left,
    output logic [SCORE_W-1:0] score,
    output logic               level_clear
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BRICKS);

    sched_state_e      state_q, state_d;
    logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
    logic              scan_rd_q, scan_rd_d;
    logic [ADDR_W-1:0] hit_addr_q, hit_addr_d;
    logic              draw_valid_q, draw_valid_d;
    logic              col_valid_q, col_valid_d;
    logic              hit_done_q, hit_done_d;
    logic [TYPE_W-1:0] hit_points_q, hit_points_d;

    logic scan_inc, scan_done, hit_upd;

    always_comb begin
        state_d      = state_q;
        scan_addr_d  = scan_addr_q;
        scan_rd_d    = 1'b0;
        hit_addr_d   = hit_addr_q;
        draw_valid_d = 1'b0;
        col_valid_d  = 1'b0;
        hit_done_d   = 1'b0;
        hit_points_d = hit_points_q;
        bus.hit_gnt  = 1'b0;
        bus.col_gnt  = 1'b0;
        bus.draw_gnt = 1'b0;
        mem_addr     = '0;
        mem_wren     = 1'b0;
        mem_data     = '0;
        scan_inc     = 1'b0;
        scan_done    = 1'b0;
        hit_upd      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!level_start) begin
                    if (bus.hit_req) begin
                        bus.hit_gnt = 1'b1;
                        mem_addr    = bus.hit_addr;
                        hit_addr_d  = bus.hit_addr;
                        state_d     = HIT_WR;
                    end else if (bus.col_req) begin
                        bus.col_gnt = 1'b1;
                        mem_addr    = bus.col_addr;
                        col_valid_d = 1'b1;
                    end else if (bus.draw_req) begin
                        bus.draw_gnt = 1'b1;
                        mem_addr     = bus.draw_addr;
                        draw_valid_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                // mem_q carries the read issued in the previous SCAN cycle
                scan_inc = scan_rd_q && (mem_q != NOBRICK);
                if (scan_addr_q < LAST_ADDR) begin
                    mem_addr    = scan_addr_q;
                    scan_addr_d = scan_addr_q + 1'b1;
                    scan_rd_d   = 1'b1;
                end else begin
                    state_d   = IDLE;
                    scan_done = !level_start;
                end
            end
            HIT_WR: begin
                state_d  = IDLE;
                mem_addr = hit_addr_q;
                // a level_start here abandons the hit entirely
                if (!level_start) begin
                    hit_upd      = 1'b1;
                    hit_done_d   = 1'b1;
                    hit_points_d = mem_q;
                    if (mem_q != NOBRICK) begin
                        mem_wren = 1'b1;
                        mem_data = mem_q - TYPE_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (level_start) begin
            state_d     = SCAN;
            scan_addr_d = '0;
            scan_rd_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            scan_addr_q  <= '0;
            scan_rd_q    <= 1'b0;
            hit_addr_q   <= '0;
            draw_valid_q <= 1'b0;
            col_valid_q  <= 1'b0;
            hit_done_q   <= 1'b0;
            hit_points_q <= '0;
        end else begin
            state_q      <= state_d;
            scan_addr_q  <= scan_addr_d;
            scan_rd_q    <= scan_rd_d;
            hit_addr_q   <= hit_addr_d;
            draw_valid_q <= draw_valid_d;
            col_valid_q  <= col_valid_d;
            hit_done_q   <= hit_done_d;
            hit_points_q <= hit_points_d;
        end
    end

    assign scan_busy      = (state_q == SCAN);
    assign bus.draw_valid = draw_valid_q;
    assign bus.col_valid  = col_valid_q;
    assign bus.rd_type    = (draw_valid_q || col_valid_q) ? mem_q : '0;
    assign bus.hit_done   = hit_done_q;
    assign bus.hit_points = hit_points_q;

    brick_tally u_tally (
        .clk         (clk),
        .reset       (reset),
        .clear       (level_start),
        .scan_inc    (scan_inc),
        .hit_upd     (hit_upd),
        .hit_old     (mem_q),
        .scan_done   (scan_done),
        .scan_busy   (scan_busy),
        .bricks_left (bricks_left),
        .score       (score),
        .level_clear (level_clear)
    );

endmodule

// File: doc/brick_mem_sched.md
# brick_mem_sched

Scheduler for the single-port level brick memory (one 3-bit brick type per address). Arbitrates drawing reads, collision reads and hit read-modify-write updates onto one memory port. Scans a level on start to count breakable bricks, then tracks bricks remaining, the score and level clear. Sits between levelDraw/brickCollision/the game FSM and the level memory instances.

## Interface
- NUM_BRICKS, 80: valid addresses 0..NUM_BRICKS-1
- ADDR_W, 8: memory address width
- TYPE_W, 3: brick type width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- level_start  in  1  one-cycle pulse: begin level scan
- scan_busy  out  1  scan in progress
- draw_req / col_req / hit_req  in  1  read request (draw, collision) or hit update request
- draw_addr / col_addr / hit_addr  in  ADDR_W  request address
- draw_gnt / col_gnt / hit_gnt  out  1  request accepted this cycle
- draw_valid / col_valid  out  1  rd_type holds that requester's data this cycle
- rd_type  out  TYPE_W  read data, shared by draw and collision
- hit_done  out  1  one-cycle pulse: update complete
- hit_points  out  TYPE_W  old type of the hit brick, valid with hit_done
- mem_addr  out  ADDR_W  memory address
- mem_wren  out  1  memory write enable
- mem_data  out  TYPE_W  memory write data
- mem_q  in  TYPE_W  memory read data, 1-cycle latency
- bricks_left  out  7  non-empty bricks remaining
- score  out  8  accumulated points
- level_clear  out  1  level fully cleared

## Operation
- Types: 0 NOBRICK, 1 RED, 2 BROWN, 3 SRED, 4 SBROWN. A hit changes type t>0 to t-1. A brick is destroyed when its old type is 1.
- States: IDLE, SCAN, HIT_WR.
- IDLE, arbitration: fixed priority hit > col > draw. At most one gnt per cycle, combinational from the req inputs. A requester holds req and addr stable until it sees gnt.
  - col/draw gnt: stay in IDLE. Back-to-back reads are pipelined.
  - hit gnt: issue the read, go to HIT_WR.
- HIT_WR: mem_q is the old type.
  - old≠0: mem_wren=1, mem_addr=hit address, mem_data=old-1.
  - old=0: no write.
  - No gnt is given in this cycle. Return to IDLE.
  - hit_done=1 next cycle, with hit_points=old.
  - score += old, saturating at 255.
  - bricks_left decrements when old=1.
- SCAN:
  - Entered on level_start from any state. Any in-flight hit is abandoned with no write and no hit_done.
  - Reads addresses 0..NUM_BRICKS-1, one per cycle, and counts mem_q≠0 into bricks_left. The count is cleared at scan entry.
  - No grants during SCAN. scan_busy=1 during SCAN.
  - level_start during SCAN restarts at address 0.
- level_clear = scanned && bricks_left==0 && !scan_busy. The scanned flag is set at the end of the first scan and held until reset.
- Reads of addresses ≥ NUM_BRICKS are issued unchanged; range checking belongs to the requester.
- score is cleared only by reset. It persists across levels.

## Timing
- Reset (async assert, sync release): state IDLE; all gnt/valid/hit_done/mem_wren/scan_busy/level_clear 0; rd_type, hit_points, mem_addr, mem_data, bricks_left, score, scanned all 0.
- Read latency: gnt in cycle N, mem_addr valid in N, *_valid and rd_type in N+1.
- Hit: gnt in N (read), write in N+1, hit_done in N+2. Earliest next grant is N+2.
- Scan of NUM_BRICKS entries:
  - level_start at cycle S: SCAN entered S+1.
  - Reads at S+1..S+NUM_BRICKS; last mem_q counted at S+NUM_BRICKS+1.
  - scan_busy high from S+1 through S+NUM_BRICKS+1; IDLE at S+NUM_BRICKS+2.
- level_start and a req in the same cycle: level_start wins, no gnt.
- bricks_left never underflows. A decrement at 0 holds 0.

## Structure
- Package brick_pkg:
  - type constants NOBRICK..SBROWN
  - NUM_BRICKS
  - state enum {IDLE, SCAN, HIT_WR}
  - shared by levelMemory, brickCollision and scoring.
- Sub-module brick_tally: bricks_left clear/increment/decrement, saturating score accumulator, level_clear. The arbiter and FSM stay in brick_mem_sched.

## Test plan
- Scan: memory preloaded with 30 non-zero entries; pulse level_start → scan_busy for 81 cycles, bricks_left=30, level_clear=0.
- Arbitration: hit_req, col_req and draw_req all high in the same cycle → hit_gnt first; col_gnt 2 cycles later; draw_gnt the cycle after that; col_valid/draw_valid each 1 cycle after their gnt.
- RMW, type 2 at address 15: hit → write data 1 to address 15, hit_points=2, score+2, bricks_left unchanged. Second hit → write 0, bricks_left-1.
- Empty hit, type 0 at address 7 → mem_wren never asserted, hit_done with hit_points=0, score unchanged.
- Clear: last brick (type 1) hit → bricks_left=0, level_clear=1. Score at 254 plus a type-3 hit → score=255.
- Robustness:
  - reset asserted mid-scan → all outputs 0 immediately.
  - level_start during HIT_WR → no write, no hit_done, scan restarts at address 0.
